cplx_conj_pipe: RTL and testbench
=================================

CPLX_CONJ_PIPE -- requirements
Module: cplx_conj_pipe

Interface
REQ-001 SHALL have parameter W, default 16: I/Q sample width, two's complement, W >= 4.
REQ-002 SHALL have parameter CW, default 8: saturation-counter width.
REQ-003 SHALL have port clk  input  1: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: input sample valid.
REQ-006 SHALL have port in_ready  output  1: block can accept a sample this cycle.
REQ-007 SHALL have port mode  input  3: operation select, sampled with the input sample.
REQ-008 SHALL have port x_i  input  W: input in-phase sample.
REQ-009 SHALL have port x_q  input  W: input quadrature sample.
REQ-010 SHALL have port out_valid  output  1: output sample valid.
REQ-011 SHALL have port out_ready  input  1: downstream accepts the output sample.
REQ-012 SHALL have port y_i  output  W: result in-phase sample.
REQ-013 SHALL have port y_q  output  W: result quadrature sample.
REQ-014 SHALL have port sat_cnt  output  CW: count of saturated samples.
REQ-015 SHALL have port sat_clr  input  1: synchronous clear of sat_cnt.

Function
REQ-016 SHALL implement modes: 0 pass (I,Q); 1 conjugate (I,-Q); 2 negate (-I,-Q); 3 swap (Q,I); 4 times j (-Q,I); 5 times -j (Q,-I); 6/7 pass.
REQ-017 SHALL saturate every negation: -(-2^(W-1)) yields 2^(W-1)-1; all other negations are exact two's complement.
REQ-018 SHALL mark a sample saturated if any component hit the REQ-017 saturation case.
REQ-019 SHALL transfer an input sample when in_valid and in_ready are both 1.
REQ-020 SHALL transfer an output sample when out_valid and out_ready are both 1.
REQ-021 SHALL use two register stages: S1 computes and registers the result and saturation flag; S2 drives y_i/y_q/out_valid.
REQ-022 SHALL deliver a sample accepted in cycle n on the outputs in cycle n+2 when out_ready is held at 1.
REQ-023 SHALL advance S1 to S2 when S1 is valid and (S2 is empty or S2 is transferring).
REQ-024 SHALL drive in_ready = !S1 valid OR S1 advancing; in_ready is combinational from out_ready.
REQ-025 SHALL hold y_i, y_q and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL never drop or duplicate a sample under any valid/ready pattern; order SHALL be preserved; full throughput is 1 sample/cycle.
REQ-027 SHALL apply the mode sampled with each sample to that sample only; a mode change mid-stream SHALL NOT affect samples already accepted.
REQ-028 SHALL increment sat_cnt by 1 when a saturated sample transfers into S1, and SHALL hold at 2^CW-1 with no wrap.
REQ-029 SHALL clear sat_cnt to 0 on sat_clr; sat_clr together with a saturating transfer SHALL yield sat_cnt=1.
REQ-030 SHALL drive y_i/y_q to 0 whenever out_valid=0.

Reset
REQ-031 SHALL, while reset=0, force S1/S2 valid=0, y_i=y_q=0, out_valid=0, in_ready=0, sat_cnt=0.
REQ-032 SHALL discard samples in flight when reset asserts mid-stream; in_ready SHALL return to 1 in the first cycle after reset deasserts.

Verification
REQ-033 SHALL pass: W=16, mode 1, x=(0x1234,0x0005), out_ready=1 -> two cycles later y=(0x1234,0xFFFB), out_valid=1.
REQ-034 SHALL pass: mode 2, x=(0x8000,0x8000) -> y=(0x7FFF,0x7FFF), sat_cnt 0->1; mode 4, x=(0x0003,0x8000) -> y=(0x7FFF,0x0003), sat_cnt=2.
REQ-035 SHALL pass: stream of 10 samples at 1/cycle with out_ready low for cycles 3-6 -> in_ready drops after S1 and S2 fill, all 10 outputs in order with no loss or duplication, y stable while stalled.
REQ-036 SHALL pass: mode switched 0->3->5 on consecutive accepted samples (0x0001,0x0002) -> outputs (1,2), (2,1), (2,0xFFFF).
REQ-037 SHALL pass: CW=2, 5 saturating samples -> sat_cnt stops at 3; sat_clr in the same cycle as a saturating transfer -> sat_cnt=1.
REQ-038 SHALL pass: reset=0 asserted with 2 samples in flight -> next cycle out_valid=0, y=0, sat_cnt=0; after release, in_ready=1 and a new sample appears 2 cycles after acceptance.

Source files
------------

// File: rtl/cplx_conj_pipe.sv
// Two-stage valid/ready pipeline applying a per-sample complex operation
// (pass, conjugate, negate, swap, times +/-j) with saturating negation and a saturation counter.
module cplx_conj_pipe #(
    parameter int W  = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    mode,
    input  logic [W-1:0]  x_i,
    input  logic [W-1:0]  x_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  y_i,
    output logic [W-1:0]  y_q,
    output logic [CW-1:0] sat_cnt,
    input  logic          sat_clr
);

    localparam logic [W-1:0]  MIN_V  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_V  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  ONE_V  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Returns {saturated, value}; only the most negative input cannot be negated exactly.
    function automatic logic [W:0] neg_sat(input logic [W-1:0] v);
        logic [W:0] r;
        if (v == MIN_V) begin
            r = {1'b1, MAX_V};
        end else begin
            r = {1'b0, (~v) + ONE_V};
        end
        return r;
    endfunction

    logic          s1_valid_q, s1_valid_d;
    logic [W-1:0]  s1_i_q, s1_i_d, s1_q_q, s1_q_d;
    logic          s2_valid_q, s2_valid_d;
    logic [W-1:0]  y_i_q, y_i_d, y_q_q, y_q_d;
    logic [CW-1:0] sat_cnt_q, sat_cnt_d;

    logic [W:0]    neg_i_s, neg_q_s;
    logic [W-1:0]  res_i_s, res_q_s;
    logic          sat_s;
    logic          s1_adv_s, in_xfer_s, s2_xfer_s;

    // Datapath: operation select and saturation detection on the incoming sample.
    always_comb begin
        neg_i_s = neg_sat(x_i);
        neg_q_s = neg_sat(x_q);
        res_i_s = x_i;
        res_q_s = x_q;
        sat_s   = 1'b0;
        case (mode)
            3'd1: begin
                res_q_s = neg_q_s[W-1:0];
                sat_s   = neg_q_s[W];
            end
            3'd2: begin
                res_i_s = neg_i_s[W-1:0];
                res_q_s = neg_q_s[W-1:0];
                sat_s   = neg_i_s[W] | neg_q_s[W];
            end
            3'd3: begin
                res_i_s = x_q;
                res_q_s = x_i;
            end
            3'd4: begin
                res_i_s = neg_q_s[W-1:0];
                res_q_s = x_i;
                sat_s   = neg_q_s[W];
            end
            3'd5: begin
                res_i_s = x_q;
                res_q_s = neg_i_s[W-1:0];
                sat_s   = neg_i_s[W];
            end
            default: begin
                res_i_s = x_i;
                res_q_s = x_q;
                sat_s   = 1'b0;
            end
        endcase
    end

    // Handshake: S1 drains into S2 when S2 is empty or emptying this cycle.
    always_comb begin
        s2_xfer_s = s2_valid_q & out_ready;
        s1_adv_s  = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready  = reset & (~s1_valid_q | s1_adv_s);
        in_xfer_s = in_valid & in_ready;
    end

    // Next-state for both stages and the saturation counter.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_i_d     = s1_i_q;
        s1_q_d     = s1_q_q;
        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
            s1_i_d     = res_i_s;
            s1_q_d     = res_q_s;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        s2_valid_d = s2_valid_q;
        y_i_d      = y_i_q;
        y_q_d      = y_q_q;
        if (s1_adv_s) begin
            s2_valid_d = 1'b1;
            y_i_d      = s1_i_q;
            y_q_d      = s1_q_q;
        end else if (s2_xfer_s) begin
            // Outputs read as zero whenever nothing valid is presented.
            s2_valid_d = 1'b0;
            y_i_d      = {W{1'b0}};
            y_q_d      = {W{1'b0}};
        end else begin
            s2_valid_d = s2_valid_q;
        end

        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = (in_xfer_s & sat_s) ? CNT_ONE : {CW{1'b0}};
        end else if (in_xfer_s && sat_s && (sat_cnt_q != CNT_MAX)) begin
            sat_cnt_d = sat_cnt_q + CNT_ONE;
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_i_q     <= {W{1'b0}};
            s1_q_q     <= {W{1'b0}};
            s2_valid_q <= 1'b0;
            y_i_q      <= {W{1'b0}};
            y_q_q      <= {W{1'b0}};
            sat_cnt_q  <= {CW{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_i_q     <= s1_i_d;
            s1_q_q     <= s1_q_d;
            s2_valid_q <= s2_valid_d;
            y_i_q      <= y_i_d;
            y_q_q      <= y_q_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign y_i       = y_i_q;
    assign y_q       = y_q_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_cplx_conj_pipe.sv
// Self-checking bench for cplx_conj_pipe: queue-based reference model, directed and random steps.
module tb_cplx_conj_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, sat_clr;
    logic [2:0]  mode;
    logic [15:0] x_i, x_q;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [15:0] y_i, y_q, y_i2, y_q2;
    logic [7:0]  sat_cnt;
    logic [1:0]  sat_cnt2;

    always #5 clk = ~clk;

    cplx_conj_pipe #(.W(16), .CW(8)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_i(x_i), .x_q(x_q), .out_valid(out_valid), .out_ready(out_ready),
        .y_i(y_i), .y_q(y_q), .sat_cnt(sat_cnt), .sat_clr(sat_clr));

    cplx_conj_pipe #(.W(16), .CW(2)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .mode(mode),
        .x_i(x_i), .x_q(x_q), .out_valid(out_valid2), .out_ready(out_ready),
        .y_i(y_i2), .y_q(y_q2), .sat_cnt(sat_cnt2), .sat_clr(sat_clr));

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        int          stamp;
    } item_t;

    item_t sb[$];
    item_t log_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc_n = 0;
    int    sat8_m = 0;
    int    sat2_m = 0;
    bit    stall_prev = 0;
    bit    last_ir;
    logic [15:0] prev_yi, prev_yq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference operation from plain signed arithmetic with clamping.
    function automatic void ref_op(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] ri, output logic [15:0] rq, output bit s);
        int ia, ib, oi, oq;
        ia = int'($signed(a));
        ib = int'($signed(b));
        case (m)
            3'd1: begin oi = ia;  oq = -ib; end
            3'd2: begin oi = -ia; oq = -ib; end
            3'd3: begin oi = ib;  oq = ia;  end
            3'd4: begin oi = -ib; oq = ia;  end
            3'd5: begin oi = ib;  oq = -ia; end
            default: begin oi = ia; oq = ib; end
        endcase
        s = 1'b0;
        if (oi > 32767) begin oi = 32767; s = 1'b1; end
        if (oq > 32767) begin oq = 32767; s = 1'b1; end
        ri = oi[15:0];
        rq = oq[15:0];
    endfunction

    // One clock cycle: drive, check against the model, clock, update the model.
    task automatic step(input bit iv, input logic [2:0] m, input logic [15:0] xi, input logic [15:0] xq,
                        input bit ordy, input bit clr, output bit acc);
        bit exp_ov, exp_ir, pop, s;
        logic [15:0] eyi, eyq, ri, rq;
        item_t it;
        in_valid = iv; mode = m; x_i = xi; x_q = xq; out_ready = ordy; sat_clr = clr;
        #3;
        exp_ov = (sb.size() > 0) && (cyc_n - sb[0].stamp >= 2);
        exp_ir = reset && ((sb.size() < 2) || ordy);
        eyi = exp_ov ? sb[0].i : 16'h0000;
        eyq = exp_ov ? sb[0].q : 16'h0000;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        chk("y_i", {16'd0, y_i}, {16'd0, eyi});
        chk("y_q", {16'd0, y_q}, {16'd0, eyq});
        chk("y_i_cw2", {16'd0, y_i2}, {16'd0, eyi});
        chk("y_q_cw2", {16'd0, y_q2}, {16'd0, eyq});
        chk("sat_cnt", {24'd0, sat_cnt}, sat8_m);
        chk("sat_cnt_cw2", {30'd0, sat_cnt2}, sat2_m);
        if (stall_prev) begin
            chk("hold_y_i", {16'd0, y_i}, {16'd0, prev_yi});
            chk("hold_y_q", {16'd0, y_q}, {16'd0, prev_yq});
        end
        last_ir = in_ready;
        acc = reset && iv && exp_ir;
        pop = reset && exp_ov && ordy;
        ref_op(m, xi, xq, ri, rq, s);
        @(posedge clk);
        #1;
        if (!reset) begin
            sb.delete();
            sat8_m = 0;
            sat2_m = 0;
            stall_prev = 1'b0;
        end else begin
            if (pop) begin
                it = sb.pop_front();
                it.stamp = cyc_n - it.stamp;
                log_q.push_back(it);
            end
            if (acc) begin
                it.i = ri; it.q = rq; it.stamp = cyc_n;
                sb.push_back(it);
            end
            if (clr) begin
                sat8_m = (acc && s) ? 1 : 0;
                sat2_m = sat8_m;
            end else if (acc && s) begin
                if (sat8_m < 255) sat8_m++;
                if (sat2_m < 3) sat2_m++;
            end
            stall_prev = exp_ov && !ordy;
            prev_yi = y_i;
            prev_yq = y_q;
        end
        cyc_n++;
    endtask

    task automatic chk_log(input int k, input logic [15:0] ei, input logic [15:0] eq, input int lat);
        if (log_q.size() > k) begin
            chk("log_i", {16'd0, log_q[k].i}, {16'd0, ei});
            chk("log_q", {16'd0, log_q[k].q}, {16'd0, eq});
            if (lat >= 0) chk("log_latency", log_q[k].stamp, lat);
        end else begin
            chk("log_present", log_q.size(), k + 1);
        end
    endtask

    initial begin
        bit a;
        bit saw_stall;
        int idx;
        reset = 1'b0; in_valid = 1'b0; mode = 3'd0; x_i = 16'h0; x_q = 16'h0;
        out_ready = 1'b1; sat_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 3'd0, 16'h1111, 16'h2222, 1'b1, 1'b0, a);
        reset = 1'b1;

        // Conjugate, two-cycle latency
        log_q.delete();
        step(1'b1, 3'd1, 16'h1234, 16'h0005, 1'b1, 1'b0, a);
        repeat (3) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk_log(0, 16'h1234, 16'hFFFB, 2);

        // Saturation cases
        log_q.delete();
        step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1, a);
        step(1'b1, 3'd2, 16'h8000, 16'h8000, 1'b1, 1'b0, a);
        chk("sat_after_first", {24'd0, sat_cnt}, 32'd1);
        step(1'b1, 3'd4, 16'h0003, 16'h8000, 1'b1, 1'b0, a);
        chk("sat_after_second", {24'd0, sat_cnt}, 32'd2);
        repeat (3) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk_log(0, 16'h7FFF, 16'h7FFF, 2);
        chk_log(1, 16'h7FFF, 16'h0003, 2);

        // Mode change on consecutive samples
        log_q.delete();
        step(1'b1, 3'd0, 16'h0001, 16'h0002, 1'b1, 1'b0, a);
        step(1'b1, 3'd3, 16'h0001, 16'h0002, 1'b1, 1'b0, a);
        step(1'b1, 3'd5, 16'h0001, 16'h0002, 1'b1, 1'b0, a);
        repeat (3) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk_log(0, 16'h0001, 16'h0002, 2);
        chk_log(1, 16'h0002, 16'h0001, 2);
        chk_log(2, 16'h0002, 16'hFFFF, 2);

        // Ten-sample stream with downstream stall
        log_q.delete();
        idx = 0;
        saw_stall = 1'b0;
        for (int t = 0; t < 40 && log_q.size() < 10; t++) begin
            step(idx < 10, 3'd0, 16'h0100 + 16'(idx), 16'(idx), !(t >= 3 && t <= 6), 1'b0, a);
            if (idx < 10 && !last_ir) saw_stall = 1'b1;
            if (a) idx++;
        end
        chk("stream_count", log_q.size(), 32'd10);
        chk("stream_stalled", {31'd0, saw_stall}, 32'd1);
        for (int k = 0; k < 10; k++) chk_log(k, 16'h0100 + 16'(k), 16'(k), -1);

        // Saturation counter limit on the narrow counter, and clear-with-increment
        step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1, a);
        repeat (5) step(1'b1, 3'd2, 16'h8000, 16'h8000, 1'b1, 1'b0, a);
        chk("sat_cw2_limit", {30'd0, sat_cnt2}, 32'd3);
        chk("sat_cw8_five", {24'd0, sat_cnt}, 32'd5);
        step(1'b1, 3'd2, 16'h8000, 16'h0000, 1'b1, 1'b1, a);
        chk("sat_clr_inc_cw2", {30'd0, sat_cnt2}, 32'd1);
        chk("sat_clr_inc_cw8", {24'd0, sat_cnt}, 32'd1);

        // Reset with samples in flight
        step(1'b1, 3'd0, 16'h0aaa, 16'h0bbb, 1'b1, 1'b0, a);
        reset = 1'b0;
        step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y_i", {16'd0, y_i}, 32'd0);
        chk("rst_y_q", {16'd0, y_q}, 32'd0);
        chk("rst_sat_cnt", {24'd0, sat_cnt}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        log_q.delete();
        step(1'b1, 3'd1, 16'h0010, 16'h0020, 1'b1, 1'b0, a);
        repeat (3) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk("rst_flushed", log_q.size(), 32'd1);
        chk_log(0, 16'h0010, 16'hFFE0, 2);

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            logic [15:0] ri, rq;
            ri = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            rq = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            reset = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ri, rq,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, a);
        end
        reset = 1'b1;
        repeat (4) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, a);
        chk("drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
